// File: rtl/me_block_scheduler.sv
// Block sequencer for the full-search motion estimation engine: one four-phase
// req/ack handshake per block, result stream, running best block, total SAD, watchdog.
//
// state     | meaning
// S_IDLE    | waiting for start, results held
// S_REQ     | me_req high, waiting for engine ack
// S_RELEASE | me_req low, waiting for engine to drop ack
// S_DONE    | one-cycle done pulse after the last block
// S_ERR     | watchdog expired, held until start
module me_block_scheduler #(
  parameter int NUM_BLOCKS     = 16,
  parameter int SAD_WIDTH      = 16,
  parameter int MVEC_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1048576,
  localparam int BLK_WIDTH     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic                           me_req,
  input  logic                           me_ack,
  input  logic [SAD_WIDTH-1:0]           me_min_sad,
  input  logic [MVEC_WIDTH-1:0]          me_min_mvec,
  output logic [BLK_WIDTH-1:0]           blk_idx,
  output logic                           res_valid,
  output logic [BLK_WIDTH-1:0]           res_idx,
  output logic [SAD_WIDTH-1:0]           res_sad,
  output logic [MVEC_WIDTH-1:0]          res_mvec,
  output logic [BLK_WIDTH-1:0]           best_idx,
  output logic [SAD_WIDTH-1:0]           best_sad,
  output logic [SAD_WIDTH+BLK_WIDTH-1:0] total_sad
);

  localparam int WD_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TOT_WIDTH = SAD_WIDTH + BLK_WIDTH;
  localparam logic [WD_WIDTH-1:0]  WD_LOAD  = WD_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [BLK_WIDTH-1:0] LAST_BLK = BLK_WIDTH'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RELEASE, S_DONE, S_ERR} state_t;

  state_t              state;
  logic                start_q;
  logic [WD_WIDTH-1:0] wd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      wd_cnt    <= WD_LOAD;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      me_req    <= 1'b0;
      blk_idx   <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_sad   <= '0;
      res_mvec  <= '0;
      best_idx  <= '0;
      best_sad  <= '1;
      total_sad <= '0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      // start is registered once; requests made while a run is active never arm it
      start_q   <= start & ~abort & (state != S_REQ) & (state != S_RELEASE);

      if (abort) begin
        state   <= S_IDLE;
        start_q <= 1'b0;
        me_req  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (start_q) begin
              state     <= S_REQ;
              me_req    <= 1'b1;
              busy      <= 1'b1;
              err       <= 1'b0;
              blk_idx   <= '0;
              best_idx  <= '0;
              best_sad  <= '1;
              total_sad <= '0;
              wd_cnt    <= WD_LOAD;
            end else if (state == S_DONE) begin
              state <= S_IDLE;
            end
          end
          S_REQ: begin
            if (me_ack) begin
              res_valid <= 1'b1;
              res_idx   <= blk_idx;
              res_sad   <= me_min_sad;
              res_mvec  <= me_min_mvec;
              total_sad <= total_sad + TOT_WIDTH'(me_min_sad);
              if (me_min_sad < best_sad) begin
                best_sad <= me_min_sad;
                best_idx <= blk_idx;
              end
              me_req <= 1'b0;
              wd_cnt <= WD_LOAD;
              state  <= S_RELEASE;
            end else if (wd_cnt == '0) begin
              state  <= S_ERR;
              err    <= 1'b1;
              me_req <= 1'b0;
              busy   <= 1'b0;
            end else begin
              wd_cnt <= wd_cnt - WD_WIDTH'(1);
            end
          end
          S_RELEASE: begin
            if (!me_ack) begin
              if (blk_idx == LAST_BLK) begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                blk_idx <= blk_idx + BLK_WIDTH'(1);
                me_req  <= 1'b1;
                wd_cnt  <= WD_LOAD;
                state   <= S_REQ;
              end
            end else if (wd_cnt == '0) begin
              state <= S_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              wd_cnt <= wd_cnt - WD_WIDTH'(1);
            end
          end
          default: begin
            state  <= S_IDLE;
            me_req <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_me_block_scheduler.sv
// Directed bench for me_block_scheduler: engine model feeds a result scoreboard,
// main sequence covers runs, ties, watchdog, abort, ignored starts and async reset.
module tb_me_block_scheduler;
  localparam int NB = 4;
  localparam int SW = 16;
  localparam int MW = 12;
  localparam int TO = 8;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst, start, abort, me_ack;
  logic [SW-1:0] me_min_sad;
  logic [MW-1:0] me_min_mvec;
  logic          busy, done, err, me_req, res_valid;
  logic [BW-1:0] blk_idx, res_idx, best_idx;
  logic [SW-1:0] res_sad, best_sad;
  logic [MW-1:0] res_mvec;
  logic [SW+BW-1:0] total_sad;

  me_block_scheduler #(
    .NUM_BLOCKS(NB), .SAD_WIDTH(SW), .MVEC_WIDTH(MW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .err(err), .me_req(me_req), .me_ack(me_ack), .me_min_sad(me_min_sad),
    .me_min_mvec(me_min_mvec), .blk_idx(blk_idx), .res_valid(res_valid),
    .res_idx(res_idx), .res_sad(res_sad), .res_mvec(res_mvec), .best_idx(best_idx),
    .best_sad(best_sad), .total_sad(total_sad)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0] idx;
    logic [SW-1:0] sad;
    logic [MW-1:0] mvec;
  } res_t;

  res_t          sb[$];
  logic [SW-1:0] sad_tab [NB];
  int            checks = 0;
  int            errors = 0;
  int            eng_blk = 0;
  bit            eng_en = 1'b1;
  int            res_seen = 0;
  int            done_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // engine model: ack 3 cycles after req, drop ack once req falls
  initial begin
    int   cnt;
    res_t e;
    cnt = 0;
    me_ack = 1'b0;
    me_min_sad = '0;
    me_min_mvec = '0;
    forever begin
      @(negedge clk);
      if (rst || !me_req) begin
        me_ack = 1'b0;
        cnt = 0;
      end else if (eng_en && !me_ack) begin
        cnt++;
        if (cnt == 3) begin
          me_ack      = 1'b1;
          me_min_sad  = sad_tab[eng_blk % NB];
          me_min_mvec = MW'(12'h0a0 + eng_blk);
          e.idx  = BW'(eng_blk);
          e.sad  = me_min_sad;
          e.mvec = me_min_mvec;
          sb.push_back(e);
          eng_blk++;
          cnt = 0;
        end
      end
    end
  end

  // result, done and request-rise monitors
  initial begin
    res_t e;
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (res_valid === 1'b1) begin
        res_seen++;
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("res_idx", 32'(res_idx), 32'(e.idx));
          check("res_sad", 32'(res_sad), 32'(e.sad));
          check("res_mvec", 32'(res_mvec), 32'(e.mvec));
        end
      end
      if (done === 1'b1) done_seen++;
      if (me_req === 1'b1 && prev_req === 1'b0) check("req_rise_ack_low", 32'(me_ack), 32'd0);
      prev_req = me_req;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit with_abort);
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic full_run(input string tag, input int exp_best, input int exp_idx, input int exp_total);
    int d0, r0;
    d0 = done_seen;
    r0 = res_seen;
    eng_blk = 0;
    pulse_start(1'b0);
    check({tag, "_req_lat"}, 32'(me_req), 32'd0);
    tick();
    check({tag, "_req"}, 32'(me_req), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_blk0"}, 32'(blk_idx), 32'd0);
    wait_done(200, {tag, "_done"});
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_best_sad"}, 32'(best_sad), 32'(exp_best));
    check({tag, "_best_idx"}, 32'(best_idx), 32'(exp_idx));
    check({tag, "_total"}, 32'(total_sad), 32'(exp_total));
    check({tag, "_last_idx"}, 32'(res_idx), 32'(NB - 1));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_done_count"}, 32'(done_seen - d0), 32'd1);
    check({tag, "_res_count"}, 32'(res_seen - r0), 32'(NB));
    check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    bit found;
    int d0;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    sad_tab = '{16'd40, 16'd12, 16'd12, 16'd7};
    #12;
    check("rst_me_req", 32'(me_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_best_sad", 32'(best_sad), 32'h0000ffff);
    check("rst_total", 32'(total_sad), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) tick();

    // run A: strict-less best update, total 71
    full_run("runA", 7, 3, 71);

    // run B: ties keep earlier block; a start while busy is ignored
    sad_tab = '{16'd5, 16'd5, 16'd9, 16'd9};
    eng_blk = 0;
    d0 = done_seen;
    pulse_start(1'b0);
    tick();
    pulse_start(1'b0);
    wait_done(200, "runB_done");
    check("runB_best_idx", 32'(best_idx), 32'd0);
    check("runB_best_sad", 32'(best_sad), 32'd5);
    check("runB_total", 32'(total_sad), 32'd28);
    repeat (4) tick();
    check("runB_done_count", 32'(done_seen - d0), 32'd1);
    check("runB_sb_drained", 32'(sb.size()), 32'd0);

    // start + abort together in IDLE does nothing
    pulse_start(1'b1);
    repeat (3) tick();
    check("sa_me_req", 32'(me_req), 32'd0);
    check("sa_busy", 32'(busy), 32'd0);
    check("sa_total_held", 32'(total_sad), 32'd28);

    // watchdog: engine never acks
    eng_en = 1'b0;
    pulse_start(1'b0);
    tick();
    check("wd_req", 32'(me_req), 32'd1);
    repeat (7) tick();
    check("wd_err_early", 32'(err), 32'd0);
    check("wd_req_early", 32'(me_req), 32'd1);
    tick();
    check("wd_err", 32'(err), 32'd1);
    check("wd_req_drop", 32'(me_req), 32'd0);
    check("wd_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("wd_err_sticky", 32'(err), 32'd1);
    eng_en = 1'b1;
    sad_tab = '{16'd40, 16'd12, 16'd12, 16'd7};
    eng_blk = 0;
    pulse_start(1'b0);
    check("wd_err_before_req", 32'(err), 32'd1);
    tick();
    check("wd_rearm_err", 32'(err), 32'd0);
    check("wd_rearm_blk", 32'(blk_idx), 32'd0);
    check("wd_rearm_req", 32'(me_req), 32'd1);
    wait_done(200, "wd_rerun_done");
    check("wd_rerun_total", 32'(total_sad), 32'd71);
    tick();

    // abort in RELEASE of block 1
    eng_blk = 0;
    d0 = done_seen;
    pulse_start(1'b0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (res_valid === 1'b1 && res_idx == BW'(1)) found = 1'b1;
    end
    check("ab_reach_blk1", 32'(found), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("ab_me_req", 32'(me_req), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    check("ab_res_valid", 32'(res_valid), 32'd0);
    check("ab_res_idx", 32'(res_idx), 32'd1);
    repeat (6) tick();
    check("ab_no_done", 32'(done_seen - d0), 32'd0);
    check("ab_idle_req", 32'(me_req), 32'd0);
    check("ab_res_idx_held", 32'(res_idx), 32'd1);
    check("ab_sb_drained", 32'(sb.size()), 32'd0);

    // async reset in the middle of REQ
    eng_blk = 0;
    pulse_start(1'b0);
    tick();
    check("rr_in_req", 32'(me_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rr_me_req", 32'(me_req), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_blk_idx", 32'(blk_idx), 32'd0);
    check("rr_res_idx", 32'(res_idx), 32'd0);
    check("rr_res_sad", 32'(res_sad), 32'd0);
    check("rr_res_mvec", 32'(res_mvec), 32'd0);
    check("rr_best_idx", 32'(best_idx), 32'd0);
    check("rr_best_sad", 32'(best_sad), 32'h0000ffff);
    check("rr_total", 32'(total_sad), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    repeat (2) tick();
    full_run("runF", 7, 3, 71);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
